// File: rtl/lsu_uncache_bridge_if.sv
// lsu_uncache_bridge_if: LSU uncached read/write buses plus single-beat AXI4-lite channels.
interface lsu_uncache_bridge_if;
  logic [38:0]  lsu_busr_req;
  logic [65:0]  lsu_busr_rsp;
  logic [118:0] lsu_busw_req;
  logic         lsu_busw_rsp;
  logic [35:0]  axi_ar;
  logic         axi_ar_ready;
  logic [66:0]  axi_r;
  logic         axi_r_ready;
  logic [35:0]  axi_aw;
  logic         axi_aw_ready;
  logic [72:0]  axi_w;
  logic         axi_w_ready;
  logic [2:0]   axi_b;
  logic         axi_b_ready;
  logic         bus_err;
  modport slave (
    input  lsu_busr_req, lsu_busw_req, axi_ar_ready, axi_r, axi_aw_ready, axi_w_ready, axi_b,
    output lsu_busr_rsp, lsu_busw_rsp, axi_ar, axi_r_ready, axi_aw, axi_w, axi_b_ready, bus_err
  );
  modport master (
    output lsu_busr_req, lsu_busw_req, axi_ar_ready, axi_r, axi_aw_ready, axi_w_ready, axi_b,
    input  lsu_busr_rsp, lsu_busw_rsp, axi_ar, axi_r_ready, axi_aw, axi_w, axi_b_ready, bus_err
  );
endinterface

// File: rtl/lsu_uncache_bridge.sv
// lsu_uncache_bridge: turns one LSU uncached load/store into one single-beat AXI4-lite transaction.
module lsu_uncache_bridge #(
  parameter bit STRB_MASK_EN = 1'b1
) (
  input logic clk,
  input logic rst_n,
  lsu_uncache_bridge_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_A, WR_B} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_addr;
  logic [2:0]  r_size;
  logic [63:0] r_wdata, r_re_data;
  logic [7:0]  r_wstrb;
  logic        r_aw_done, r_w_done, r_re_valid, r_bus_err;
  logic        w_r_req, w_w_req, w_r_rdy, w_w_rdy, w_rvalid, w_bvalid, w_awvalid, w_wvalid, w_unused;
  logic [31:0] w_raddr, w_waddr;
  logic [5:0]  w_rtype, w_wtype;
  logic [63:0] w_wdata_in, w_rdata;
  logic [7:0]  w_strb_in, w_wmask;
  logic [2:0]  w_wsize;
  logic [1:0]  w_rresp, w_bresp;
  function automatic logic [2:0] size_of(input logic [5:0] t);
    return t == 6'd0 ? 3'd0 : t == 6'd1 ? 3'd1 : t == 6'd3 ? 3'd2 : 3'd3;
  endfunction
  assign {w_raddr, w_rtype, w_r_req} = bus.lsu_busr_req;
  assign {w_waddr, w_wdata_in, w_wtype} = bus.lsu_busw_req[118:17];
  assign w_strb_in = bus.lsu_busw_req[8:1];
  assign w_w_req   = bus.lsu_busw_req[0];
  assign w_unused  = ^bus.lsu_busw_req[16:9];
  assign {w_rdata, w_rresp, w_rvalid} = bus.axi_r;
  assign {w_bresp, w_bvalid} = bus.axi_b;
  assign w_wsize   = size_of(w_wtype);
  assign w_wmask   = w_wsize == 3'd0 ? 8'h01 : w_wsize == 3'd1 ? 8'h03 : w_wsize == 3'd2 ? 8'h0f : 8'hff;
  assign w_awvalid = r_state == WR_A && !r_aw_done;
  assign w_wvalid  = r_state == WR_A && !r_w_done;
  assign bus.lsu_busr_rsp = {r_re_data, w_r_rdy, r_re_valid};
  assign bus.lsu_busw_rsp = w_w_rdy;
  assign bus.axi_ar       = {r_addr, r_size, r_state == RD_A};
  assign bus.axi_r_ready  = r_state == RD_D;
  assign bus.axi_aw       = {r_addr, r_size, w_awvalid};
  assign bus.axi_w        = {r_wdata, r_wstrb, w_wvalid};
  assign bus.axi_b_ready  = r_state == WR_B;
  assign bus.bus_err      = r_bus_err;
  always_ff @(posedge clk)
    r_state <= !rst_n ? IDLE : w_next;
  always_comb begin
    w_next  = r_state;
    w_r_rdy = 1'b0;
    w_w_rdy = 1'b0;
    case (r_state)
      IDLE: begin
        w_w_rdy = rst_n & w_w_req;
        w_r_rdy = rst_n & w_r_req & ~w_w_req;
        w_next  = w_w_req ? WR_A : w_r_req ? RD_A : IDLE;
      end
      RD_A:    w_next = bus.axi_ar_ready ? RD_D : RD_A;
      RD_D:    w_next = w_rvalid ? IDLE : RD_D;
      WR_A:    w_next = (r_aw_done | bus.axi_aw_ready) & (r_w_done | bus.axi_w_ready) ? WR_B : WR_A;
      WR_B:    w_next = w_bvalid ? IDLE : WR_B;
      default: w_next = IDLE;
    endcase
  end
  // payload is aligned once at capture so it stays stable for the whole handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_size     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_re_data  <= '0;
      r_re_valid <= 1'b0;
      r_bus_err  <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      r_re_valid <= r_state == RD_D && w_rvalid;
      r_bus_err  <= (r_state == RD_D && w_rvalid && w_rresp != 2'b00) ||
                    (r_state == WR_B && w_bvalid && w_bresp != 2'b00);
      if (r_state == RD_D && w_rvalid) r_re_data <= w_rdata >> {r_addr[2:0], 3'b000};
      if (r_state == IDLE && w_w_req) begin
        r_addr    <= w_waddr;
        r_size    <= w_wsize;
        r_wdata   <= w_wdata_in << {w_waddr[2:0], 3'b000};
        r_wstrb   <= (w_wmask << w_waddr[2:0]) & (STRB_MASK_EN ? w_strb_in : 8'hff);
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else if (r_state == IDLE && w_r_req) begin
        r_addr <= w_raddr;
        r_size <= size_of(w_rtype);
      end
      if (w_awvalid && bus.axi_aw_ready) r_aw_done <= 1'b1;
      if (w_wvalid && bus.axi_w_ready) r_w_done <= 1'b1;
    end
  end
endmodule

// File: tb/tb_lsu_uncache_bridge.sv
// tb_lsu_uncache_bridge: directed scenarios plus randomized loads/stores checked against a byte-lane model.
module tb_lsu_uncache_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  lsu_uncache_bridge_if bus();
  lsu_uncache_bridge dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic        r_rdy, re_valid, w_rdy, arvalid, rready, awvalid, wvalid, bready, bus_err;
  logic [63:0] re_data, wdata;
  logic [31:0] araddr, awaddr;
  logic [2:0]  arsize, awsize;
  logic [7:0]  wstrb;
  logic [214:0] all_out;
  assign {re_data, r_rdy, re_valid} = bus.lsu_busr_rsp;
  assign w_rdy = bus.lsu_busw_rsp;
  assign {araddr, arsize, arvalid} = bus.axi_ar;
  assign {awaddr, awsize, awvalid} = bus.axi_aw;
  assign {wdata, wstrb, wvalid} = bus.axi_w;
  assign rready = bus.axi_r_ready;
  assign bready = bus.axi_b_ready;
  assign bus_err = bus.bus_err;
  assign all_out = {bus.lsu_busr_rsp, bus.lsu_busw_rsp, bus.axi_ar, bus.axi_r_ready, bus.axi_aw,
                    bus.axi_w, bus.axi_b_ready, bus.bus_err};

  function automatic logic [2:0] m_size(input logic [5:0] t);
    case (t)
      6'd0: return 3'd0;
      6'd1: return 3'd1;
      6'd3: return 3'd2;
      default: return 3'd3;
    endcase
  endfunction
  function automatic logic [63:0] m_rdata(input logic [63:0] d, input logic [31:0] a);
    return d >> (8 * int'(a[2:0]));
  endfunction
  function automatic logic [63:0] m_wdata(input logic [63:0] d, input logic [31:0] a);
    logic [63:0] r = '0;
    int off = int'(a[2:0]);
    for (int b = off; b < 8; b++) r[8*b +: 8] = d[8*(b-off) +: 8];
    return r;
  endfunction
  function automatic logic [7:0] m_strb(input logic [31:0] a, input logic [5:0] t, input logic [15:0] s);
    logic [7:0] r = '0;
    int off = int'(a[2:0]);
    int nb = 1 << m_size(t);
    for (int b = off; b < 8 && b < off + nb; b++) r[b] = s[b];
    return r;
  endfunction

  task automatic idle_in();
    bus.lsu_busr_req = '0; bus.lsu_busw_req = '0;
    bus.axi_ar_ready = 1'b0; bus.axi_r = '0; bus.axi_aw_ready = 1'b0;
    bus.axi_w_ready = 1'b0; bus.axi_b = '0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [5:0] t, input logic [63:0] d, input logic [1:0] rr,
                         input int ard, input int rd, output logic rdy, output logic [31:0] aa,
                         output logic [2:0] as, output logic [63:0] q, output logic v, output logic e,
                         output logic fl);
    fl = 1'b1;
    @(negedge clk); bus.lsu_busr_req = {a, t, 1'b1};
    #1 rdy = r_rdy;
    @(negedge clk); bus.lsu_busr_req = '0;
    #1 aa = araddr; as = arsize;
    for (int c = 0; c <= ard; c++) begin
      if (arvalid !== 1'b1 || araddr !== aa || arsize !== as || rready !== 1'b0) fl = 1'b0;
      bus.axi_ar_ready = (c == ard);
      @(negedge clk); #1;
    end
    bus.axi_ar_ready = 1'b0;
    for (int c = 0; c < rd; c++) begin
      if (rready !== 1'b1 || arvalid !== 1'b0 || re_valid !== 1'b0) fl = 1'b0;
      @(negedge clk); #1;
    end
    if (rready !== 1'b1) fl = 1'b0;
    bus.axi_r = {d, rr, 1'b1};
    @(negedge clk); bus.axi_r = '0;
    #1 v = re_valid; q = re_data; e = bus_err;
    @(negedge clk);
    #1 if (re_valid !== 1'b0 || bus_err !== 1'b0) fl = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [5:0] t, input logic [63:0] d, input logic [15:0] s,
                          input int awd, input int wd, input int bd, input logic [1:0] br,
                          output logic rdy, output logic [31:0] aa, output logic [2:0] as,
                          output logic [63:0] wq, output logic [7:0] ws, output logic e, output logic fl);
    fl = 1'b1;
    @(negedge clk); bus.lsu_busw_req = {a, d, t, s, 1'b1};
    #1 rdy = w_rdy;
    @(negedge clk); bus.lsu_busw_req = '0;
    #1 aa = awaddr; as = awsize; wq = wdata; ws = wstrb;
    for (int c = 0; c <= (awd > wd ? awd : wd); c++) begin
      if (awvalid !== (c <= awd) || wvalid !== (c <= wd) || bready !== 1'b0 || w_rdy !== 1'b0 ||
          awaddr !== aa || awsize !== as || wdata !== wq || wstrb !== ws) fl = 1'b0;
      bus.axi_aw_ready = (c == awd); bus.axi_w_ready = (c == wd);
      @(negedge clk); #1;
    end
    bus.axi_aw_ready = 1'b0; bus.axi_w_ready = 1'b0;
    for (int c = 0; c < bd; c++) begin
      if (bready !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0) fl = 1'b0;
      @(negedge clk); #1;
    end
    if (bready !== 1'b1) fl = 1'b0;
    bus.axi_b = {br, 1'b1};
    @(negedge clk); bus.axi_b = '0;
    #1 e = bus_err;
    if (bready !== 1'b0 || re_valid !== 1'b0) fl = 1'b0;
    @(negedge clk);
    #1 if (bus_err !== 1'b0) fl = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_in();
    repeat (3) @(negedge clk);
    #1 n_chk++;
    if (all_out !== '0) begin n_err++; $display("FAIL reset_held got=%h exp=0", all_out); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    #1 n_chk++;
    if (all_out !== '0) begin n_err++; $display("FAIL reset_released got=%h exp=0", all_out); end
  endtask

  task automatic test_load_basic();
    @(negedge clk); bus.lsu_busr_req = {32'ha0000004, 6'd3, 1'b1}; bus.axi_ar_ready = 1'b1;
    #1 n_chk++;
    if (r_rdy !== 1'b1) begin n_err++; $display("FAIL load_r_rdy_t0 got=%b exp=1", r_rdy); end
    @(negedge clk); bus.lsu_busr_req = '0;
    #1 n_chk++;
    if ({arvalid, araddr, arsize, r_rdy} !== {1'b1, 32'ha0000004, 3'd2, 1'b0}) begin
      n_err++; $display("FAIL load_ar_t1 got=%b/%h/%0d/%b exp=1/a0000004/2/0", arvalid, araddr, arsize, r_rdy);
    end
    @(negedge clk); bus.axi_ar_ready = 1'b0; bus.axi_r = {64'h1122334455667788, 2'b00, 1'b1};
    #1 n_chk++;
    if ({rready, arvalid, re_valid} !== 3'b100) begin
      n_err++; $display("FAIL load_r_t2 got=%b%b%b exp=100", rready, arvalid, re_valid);
    end
    @(negedge clk); bus.axi_r = '0;
    #1 n_chk++;
    if ({re_valid, re_data, bus_err} !== {1'b1, 64'h11223344, 1'b0}) begin
      n_err++; $display("FAIL load_rsp_t3 got=%b/%h/%b exp=1/11223344/0", re_valid, re_data, bus_err);
    end
    @(negedge clk);
    #1 n_chk++;
    if ({re_valid, rready} !== 2'b00) begin
      n_err++; $display("FAIL load_t4_idle got=%b%b exp=00", re_valid, rready);
    end
  endtask

  task automatic test_store_basic();
    @(negedge clk); bus.lsu_busw_req = {32'ha0000003, 64'hab, 6'd0, 16'hffff, 1'b1};
    #1 n_chk++;
    if (w_rdy !== 1'b1) begin n_err++; $display("FAIL store_w_rdy_t0 got=%b exp=1", w_rdy); end
    @(negedge clk); bus.lsu_busw_req = '0;
    #1 n_chk++;
    if ({awvalid, wvalid, awaddr, awsize, wstrb, wdata} !==
        {2'b11, 32'ha0000003, 3'd0, 8'h08, 64'h00000000ab000000}) begin
      n_err++; $display("FAIL store_aw_w got=%b%b/%h/%0d/%h/%h exp=11/a0000003/0/08/00000000ab000000",
                        awvalid, wvalid, awaddr, awsize, wstrb, wdata);
    end
    bus.axi_aw_ready = 1'b1; bus.axi_w_ready = 1'b1;
    @(negedge clk); bus.axi_aw_ready = 1'b0; bus.axi_w_ready = 1'b0;
    #1 n_chk++;
    if ({bready, awvalid, wvalid} !== 3'b100) begin
      n_err++; $display("FAIL store_wr_b got=%b%b%b exp=100", bready, awvalid, wvalid);
    end
    @(negedge clk);
    #1 n_chk++;
    if (bready !== 1'b1) begin n_err++; $display("FAIL store_bready_hold got=%b exp=1", bready); end
    bus.axi_b = 3'b001;
    @(negedge clk); bus.axi_b = '0;
    #1 n_chk++;
    if ({bready, bus_err, re_valid} !== 3'b000) begin
      n_err++; $display("FAIL store_done got=%b%b%b exp=000", bready, bus_err, re_valid);
    end
  endtask

  task automatic test_split_handshake();
    logic rdy, e, fl; logic [31:0] aa; logic [2:0] as; logic [63:0] wq; logic [7:0] ws;
    logic [63:0] d;
    for (int k = 0; k < 2; k++) begin
      d = {$urandom, $urandom};
      do_store(32'h80001004, 6'd3, d, 16'hffff, k == 0 ? 0 : 3, k == 0 ? 3 : 0, 1, 2'b00,
               rdy, aa, as, wq, ws, e, fl);
      n_chk++;
      if ({rdy, aa, as, wq, ws, e, fl} !== {1'b1, 32'h80001004, 3'd2, m_wdata(d, 32'h80001004),
                                             m_strb(32'h80001004, 6'd3, 16'hffff), 1'b0, 1'b1}) begin
        n_err++; $display("FAIL split_hs%0d got=%b/%h/%0d/%h/%h/%b/flow%b exp=1/80001004/2/%h/%h/0/flow1", k,
                          rdy, aa, as, wq, ws, e, fl, m_wdata(d, 32'h80001004),
                          m_strb(32'h80001004, 6'd3, 16'hffff));
      end
    end
  endtask

  task automatic test_posted_order();
    @(negedge clk); bus.lsu_busw_req = {32'h40000008, 64'h55, 6'd0, 16'hffff, 1'b1};
    @(negedge clk); bus.lsu_busw_req = '0; bus.lsu_busr_req = {32'h40000010, 6'd7, 1'b1};
    bus.axi_aw_ready = 1'b1; bus.axi_w_ready = 1'b1;
    #1 n_chk++;
    if (r_rdy !== 1'b0) begin n_err++; $display("FAIL order_r_rdy_wr_a got=%b exp=0", r_rdy); end
    @(negedge clk); bus.axi_aw_ready = 1'b0; bus.axi_w_ready = 1'b0;
    #1 n_chk++;
    if ({bready, r_rdy} !== 2'b10) begin n_err++; $display("FAIL order_wr_b got=%b%b exp=10", bready, r_rdy); end
    @(negedge clk);
    #1 n_chk++;
    if ({r_rdy, arvalid} !== 2'b00) begin
      n_err++; $display("FAIL order_wait_b got=%b%b exp=00", r_rdy, arvalid);
    end
    bus.axi_b = 3'b001;
    @(negedge clk); bus.axi_b = '0;
    #1 n_chk++;
    if ({r_rdy, arvalid} !== 2'b10) begin
      n_err++; $display("FAIL order_after_b got=%b%b exp=10", r_rdy, arvalid);
    end
    @(negedge clk); bus.lsu_busr_req = '0;
    #1 n_chk++;
    if ({arvalid, araddr, arsize} !== {1'b1, 32'h40000010, 3'd3}) begin
      n_err++; $display("FAIL order_ar got=%b/%h/%0d exp=1/40000010/3", arvalid, araddr, arsize);
    end
    bus.axi_ar_ready = 1'b1;
    @(negedge clk); bus.axi_ar_ready = 1'b0; bus.axi_r = {64'hcafef00d12345678, 2'b00, 1'b1};
    @(negedge clk); bus.axi_r = '0;
    #1 n_chk++;
    if ({re_valid, re_data} !== {1'b1, 64'hcafef00d12345678}) begin
      n_err++; $display("FAIL order_load_data got=%b/%h exp=1/cafef00d12345678", re_valid, re_data);
    end
  endtask

  task automatic test_rresp_err();
    logic rdy, v, e, fl; logic [31:0] aa; logic [2:0] as; logic [63:0] q, d;
    d = {$urandom, $urandom};
    do_load(32'h10000006, 6'd1, d, 2'b10, 1, 2, rdy, aa, as, q, v, e, fl);
    n_chk++;
    if ({v, e, q, fl} !== {1'b1, 1'b1, m_rdata(d, 32'h10000006), 1'b1}) begin
      n_err++; $display("FAIL rresp_err got=%b/%b/%h/flow%b exp=1/1/%h/flow1", v, e, q, fl,
                        m_rdata(d, 32'h10000006));
    end
  endtask

  task automatic test_reset_mid();
    logic rdy, v, e, fl; logic [31:0] aa; logic [2:0] as; logic [63:0] q;
    @(negedge clk); bus.lsu_busr_req = {32'h20000000, 6'd7, 1'b1};
    @(negedge clk); bus.lsu_busr_req = '0; bus.axi_ar_ready = 1'b1;
    @(negedge clk); bus.axi_ar_ready = 1'b0;
    #1 n_chk++;
    if (rready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_rd_d got=%b exp=1", rready); end
    bus.axi_r = {64'hdeadbeefdeadbeef, 2'b00, 1'b1}; rst_n = 1'b0;
    @(negedge clk);
    #1 n_chk++;
    if (all_out !== '0) begin n_err++; $display("FAIL rstmid_outputs got=%h exp=0", all_out); end
    rst_n = 1'b1; bus.axi_r = '0;
    @(negedge clk);
    #1 n_chk++;
    if (all_out !== '0) begin n_err++; $display("FAIL rstmid_after got=%h exp=0", all_out); end
    do_load(32'h20000001, 6'd0, 64'h0000000000009a00, 2'b00, 0, 0, rdy, aa, as, q, v, e, fl);
    n_chk++;
    if ({rdy, v, q, e, fl} !== {2'b11, 64'h9a, 2'b01}) begin
      n_err++; $display("FAIL rstmid_recover got=%b/%b/%h/%b/flow%b exp=1/1/9a/0/flow1", rdy, v, q, e, fl);
    end
  endtask

  task automatic test_random();
    logic rdy, v, e, fl; logic [31:0] aa, a; logic [2:0] as; logic [63:0] q, d; logic [7:0] ws;
    logic [5:0] t; logic [15:0] s; logic [1:0] rr; int k;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; d = {$urandom, $urandom}; s = 16'($urandom); rr = 2'($urandom_range(0, 3));
      k = $urandom_range(0, 4);
      t = k == 4 ? 6'd5 : 6'((1 << k) - 1);
      if ($urandom_range(0, 1) == 0) begin
        do_load(a, t, d, rr, $urandom_range(0, 3), $urandom_range(0, 3), rdy, aa, as, q, v, e, fl);
        n_chk++;
        if ({rdy, aa, as, v, q, e, fl} !== {1'b1, a, m_size(t), 1'b1, m_rdata(d, a), rr != 2'b00, 1'b1}) begin
          n_err++; $display("FAIL rand_load%0d got=%b/%h/%0d/%b/%h/%b/flow%b exp=1/%h/%0d/1/%h/%b/flow1", i,
                            rdy, aa, as, v, q, e, fl, a, m_size(t), m_rdata(d, a), rr != 2'b00);
        end
      end else begin
        do_store(a, t, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), rr,
                 rdy, aa, as, q, ws, e, fl);
        n_chk++;
        if ({rdy, aa, as, q, ws, e, fl} !== {1'b1, a, m_size(t), m_wdata(d, a), m_strb(a, t, s),
                                              rr != 2'b00, 1'b1}) begin
          n_err++; $display("FAIL rand_store%0d got=%b/%h/%0d/%h/%h/%b/flow%b exp=1/%h/%0d/%h/%h/%b/flow1", i,
                            rdy, aa, as, q, ws, e, fl, a, m_size(t), m_wdata(d, a), m_strb(a, t, s), rr != 2'b00);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_store_basic();
    test_split_handshake();
    test_posted_order();
    test_rresp_err();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end
endmodule
